// File: rtl/conv_window_sequencer_if.sv
// Handshake and address bus between the convolution controller and the window sequencer.
// The pad signal exists only when ZERO_PAD_EN is defined.
interface conv_window_sequencer_if #(
  parameter int AW = 4,
  parameter int TW = 4,
  parameter int WW = 2
);
  logic          start;
  logic          adv;
  logic          abort;
  logic [AW-1:0] pix_addr;
  logic [TW-1:0] tap_idx;
  logic          tap_valid;
  logic          acc_clr;
  logic          acc_last;
  logic [WW-1:0] win_idx;
  logic          busy;
  logic          done;
`ifdef ZERO_PAD_EN
  logic          pad;
`endif

  modport master (
    output start, adv, abort,
`ifdef ZERO_PAD_EN
    input  pad,
`endif
    input  pix_addr, tap_idx, tap_valid, acc_clr, acc_last, win_idx, busy, done
  );

  modport slave (
    input  start, adv, abort,
`ifdef ZERO_PAD_EN
    output pad,
`endif
    output pix_addr, tap_idx, tap_valid, acc_clr, acc_last, win_idx, busy, done
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Walks a KxK kernel over an IMG_H x IMG_W image, one (pixel, tap) pair per adv cycle.
// Define ZERO_PAD_EN for "same" convolution: padded taps raise pad and force pix_addr to 0.
module conv_window_sequencer #(
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input logic CLK,
  input logic RESET,
  conv_window_sequencer_if.slave io_seq
);
`ifdef ZERO_PAD_EN
  localparam int P  = (K - 1) / 2;
  localparam int OW = IMG_W;
  localparam int OH = IMG_H;
`else
  localparam int P  = 0;
  localparam int OW = (IMG_W - K) / STRIDE + 1;
  localparam int OH = (IMG_H - K) / STRIDE + 1;
`endif
  localparam int AW  = $clog2(IMG_W * IMG_H);
  localparam int TW  = $clog2(K * K);
  localparam int WW  = (OW * OH > 1) ? $clog2(OW * OH) : 1;
  localparam int KCW = (K > 1) ? $clog2(K) : 1;
  localparam int OCW = (OW > 1) ? $clog2(OW) : 1;
  localparam int ORW = (OH > 1) ? $clog2(OH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  logic           r_busy;
  logic           r_done;
  logic [KCW-1:0] r_kc;
  logic [KCW-1:0] r_kr;
  logic [OCW-1:0] r_oc;
  logic [ORW-1:0] r_orow;

  logic w_kc_last, w_kr_last, w_oc_last, w_orow_last, w_final;
  int   w_row, w_col, w_lin;
  logic w_oob;

  assign w_kc_last   = (r_kc == KCW'(K - 1));
  assign w_kr_last   = (r_kr == KCW'(K - 1));
  assign w_oc_last   = (r_oc == OCW'(OW - 1));
  assign w_orow_last = (r_orow == ORW'(OH - 1));
  assign w_final     = w_kc_last & w_kr_last & w_oc_last & w_orow_last;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_kc    <= '0;
      r_kr    <= '0;
      r_oc    <= '0;
      r_orow  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_seq.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_kc    <= '0;
            r_kr    <= '0;
            r_oc    <= '0;
            r_orow  <= '0;
          end
        end
        S_RUN: begin
          // abort wins over adv so a stalled or advancing pass both drop cleanly
          if (io_seq.abort || (io_seq.adv && w_final)) begin
            r_state <= io_seq.abort ? S_IDLE : S_DONE;
            r_done  <= ~io_seq.abort;
            r_busy  <= 1'b0;
            r_kc    <= '0;
            r_kr    <= '0;
            r_oc    <= '0;
            r_orow  <= '0;
          end else if (io_seq.adv) begin
            r_kc <= w_kc_last ? '0 : r_kc + KCW'(1);
            if (w_kc_last) begin
              r_kr <= w_kr_last ? '0 : r_kr + KCW'(1);
              if (w_kr_last) begin
                r_oc <= w_oc_last ? '0 : r_oc + OCW'(1);
                if (w_oc_last) r_orow <= r_orow + ORW'(1);
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Signed image coordinates; P is 0 without padding so the bounds test never fires.
  assign w_row = int'(r_orow) * STRIDE + int'(r_kr) - P;
  assign w_col = int'(r_oc) * STRIDE + int'(r_kc) - P;
  assign w_lin = w_row * IMG_W + w_col;
  assign w_oob = (w_row < 0) || (w_row >= IMG_H) || (w_col < 0) || (w_col >= IMG_W);

  assign io_seq.pix_addr  = (r_busy && !w_oob) ? AW'(w_lin) : '0;
  assign io_seq.tap_idx   = TW'(int'(r_kr) * K + int'(r_kc));
  assign io_seq.win_idx   = WW'(int'(r_orow) * OW + int'(r_oc));
  assign io_seq.tap_valid = r_busy;
  assign io_seq.busy      = r_busy;
  assign io_seq.done      = r_done;
  assign io_seq.acc_clr   = r_busy && (r_kc == '0) && (r_kr == '0);
  assign io_seq.acc_last  = r_busy && w_kc_last && w_kr_last;
`ifdef ZERO_PAD_EN
  assign io_seq.pad       = r_busy && w_oob;
`endif
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Runs a default-geometry sequencer and a 6x6 stride-2 sequencer side by side from shared stimulus.
// Expected taps come from a behavioural scoreboard queue per instance.
`timescale 1ns/1ps
module tb_conv_window_sequencer;
  localparam int W0 = 4, H0 = 4, K0 = 3, S0 = 1;
  localparam int W1 = 6, H1 = 6, K1 = 3, S1 = 2;
`ifdef ZERO_PAD_EN
  localparam int OW0 = W0, OH0 = H0, OW1 = W1, OH1 = H1;
`else
  localparam int OW0 = (W0 - K0) / S0 + 1, OH0 = (H0 - K0) / S0 + 1;
  localparam int OW1 = (W1 - K1) / S1 + 1, OH1 = (H1 - K1) / S1 + 1;
`endif
  localparam int AW0 = $clog2(W0 * H0), TW0 = $clog2(K0 * K0);
  localparam int AW1 = $clog2(W1 * H1), TW1 = $clog2(K1 * K1);
  localparam int WW0 = (OW0 * OH0 > 1) ? $clog2(OW0 * OH0) : 1;
  localparam int WW1 = (OW1 * OH1 > 1) ? $clog2(OW1 * OH1) : 1;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  tap;
    logic [7:0]  win;
    logic        vld;
    logic        clr;
    logic        last;
    logic        busy;
    logic        pad;
  } tap_t;

  logic CLK = 1'b0;
  logic RESET;
  logic start, adv, abort;
  int   total = 0;
  int   bad   = 0;

  tap_t q [2][$];
  tap_t scratch [$];
  tap_t seen0 [512];
  tap_t seen1 [512];
  int   done_at [2];

  always #5 CLK = ~CLK;

  conv_window_sequencer_if #(.AW(AW0), .TW(TW0), .WW(WW0)) bus0 ();
  conv_window_sequencer_if #(.AW(AW1), .TW(TW1), .WW(WW1)) bus1 ();
  assign bus0.start = start;
  assign bus0.adv   = adv;
  assign bus0.abort = abort;
  assign bus1.start = start;
  assign bus1.adv   = adv;
  assign bus1.abort = abort;

  conv_window_sequencer #(.IMG_W(W0), .IMG_H(H0), .K(K0), .STRIDE(S0)) dut0 (
    .CLK(CLK), .RESET(RESET), .io_seq(bus0));
  conv_window_sequencer #(.IMG_W(W1), .IMG_H(H1), .K(K1), .STRIDE(S1)) dut1 (
    .CLK(CLK), .RESET(RESET), .io_seq(bus1));

  function automatic tap_t obs(input int d);
    tap_t t;
    t = '0;
    if (d == 0) begin
      t.addr = 16'(bus0.pix_addr); t.tap = 8'(bus0.tap_idx); t.win = 8'(bus0.win_idx);
      t.vld = bus0.tap_valid; t.clr = bus0.acc_clr; t.last = bus0.acc_last; t.busy = bus0.busy;
`ifdef ZERO_PAD_EN
      t.pad = bus0.pad;
`endif
    end else begin
      t.addr = 16'(bus1.pix_addr); t.tap = 8'(bus1.tap_idx); t.win = 8'(bus1.win_idx);
      t.vld = bus1.tap_valid; t.clr = bus1.acc_clr; t.last = bus1.acc_last; t.busy = bus1.busy;
`ifdef ZERO_PAD_EN
      t.pad = bus1.pad;
`endif
    end
    return t;
  endfunction

  function automatic logic done_of(input int d);
    return (d == 0) ? bus0.done : bus1.done;
  endfunction

  task automatic build(input int w, input int h, input int k, input int s);
    int p, ow, oh, r, c;
    tap_t t;
`ifdef ZERO_PAD_EN
    p = (k - 1) / 2; ow = w; oh = h;
`else
    p = 0; ow = (w - k) / s + 1; oh = (h - k) / s + 1;
`endif
    scratch.delete();
    for (int orow = 0; orow < oh; orow++)
      for (int oc = 0; oc < ow; oc++)
        for (int kr = 0; kr < k; kr++)
          for (int kc = 0; kc < k; kc++) begin
            r = orow * s + kr - p;
            c = oc * s + kc - p;
            t = '0;
            t.vld  = 1'b1;
            t.busy = 1'b1;
            t.tap  = 8'(kr * k + kc);
            t.win  = 8'(orow * ow + oc);
            t.clr  = (kr == 0) && (kc == 0);
            t.last = (kr == k - 1) && (kc == k - 1);
            t.pad  = (r < 0) || (r >= h) || (c < 0) || (c >= w);
            t.addr = t.pad ? 16'd0 : 16'(r * w + c);
            scratch.push_back(t);
          end
  endtask

  task automatic check_idle(input string name);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs(d) !== '0 || done_of(d) !== 1'b0) begin
        bad++;
        $display("FAIL %s dut%0d: got outputs %h done %b, want all zero", name, d, obs(d), done_of(d));
      end
    end
  endtask

  // mode 0: adv held high; mode 1: adv alternates 0,1 starting low.
  task automatic run_pass(input int mode, input int restart_at, input int abort_at);
    int   c, ntap [2], runs [2], ndone [2], nseen [2];
    bit   fin, adv_n;
    tap_t o;
    build(W0, H0, K0, S0); q[0] = scratch;
    build(W1, H1, K1, S1); q[1] = scratch;
    for (int d = 0; d < 2; d++) begin
      ntap[d] = q[d].size(); runs[d] = 0; ndone[d] = 0; nseen[d] = 0; done_at[d] = 0;
    end
    @(negedge CLK); start = 1'b1; adv = 1'b0; abort = 1'b0;
    @(negedge CLK);
    c = 1; fin = 1'b0;
    while (!fin) begin
      adv_n = (mode == 0) ? 1'b1 : (c % 2 == 0);
      for (int d = 0; d < 2; d++) begin
        o = obs(d);
        if (o.vld) begin
          runs[d]++;
          total++;
          if (q[d].size() == 0) begin
            bad++;
            $display("FAIL tap dut%0d cycle %0d: got %h, want no tap (queue empty)", d, c, o);
          end else begin
            if (o !== q[d][0]) begin
              bad++;
              $display("FAIL tap dut%0d cycle %0d: got %h want %h", d, c, o, q[d][0]);
            end
            if (adv_n) begin
              if (d == 0) seen0[nseen[0]] = o; else seen1[nseen[1]] = o;
              nseen[d]++;
              void'(q[d].pop_front());
            end
          end
        end
        if (done_of(d)) begin
          ndone[d]++;
          if (done_at[d] == 0) done_at[d] = c;
          total++;
          if (o.vld || o.busy) begin
            bad++;
            $display("FAIL done_flags dut%0d: got valid %b busy %b, want 0 0", d, o.vld, o.busy);
          end
        end
      end
      start = (c == restart_at);
      adv = adv_n;
      if (c == abort_at) begin
        abort = 1'b1; adv = 1'b1; fin = 1'b1;
      end
      if (done_at[0] != 0 && done_at[1] != 0) fin = 1'b1;
      if (c >= 4000) begin
        bad++; total++; fin = 1'b1;
        $display("FAIL timeout: got no done after %0d cycles, want done", c);
      end
      c++;
      if (!fin) @(negedge CLK);
    end
    @(negedge CLK);
    start = 1'b0; abort = 1'b0; adv = 1'b0;
    if (abort_at != 0) begin
      check_idle("abort_idle");
      repeat (3) begin
        @(negedge CLK);
        check_idle("abort_no_done");
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (done_of(d)) ndone[d]++;
        total++;
        if (runs[d] != ntap[d] * (mode + 1) || done_at[d] != ntap[d] * (mode + 1) + 1 || ndone[d] != 1) begin
          bad++;
          $display("FAIL pass_len dut%0d: got run %0d done@%0d pulses %0d, want run %0d done@%0d pulses 1",
                   d, runs[d], done_at[d], ndone[d], ntap[d] * (mode + 1), ntap[d] * (mode + 1) + 1);
        end
      end
      check_idle("post_done_idle");
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b0; adv = 1'b0; abort = 1'b0;
    #12;
    check_idle("reset_state");
    @(negedge CLK); RESET = 1'b0;
    @(negedge CLK);
    check_idle("after_reset");
  endtask

  task automatic test_full_pass();
    int exp_addr [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    run_pass(0, 0, 0);
`ifdef ZERO_PAD_EN
    total++;
    if (seen0[0].pad !== 1'b1 || seen0[0].addr !== 16'd0) begin
      bad++; $display("FAIL pad_first: got pad %b addr %0d, want pad 1 addr 0", seen0[0].pad, seen0[0].addr);
    end
    total++;
    if (seen0[4].pad !== 1'b0 || seen0[4].addr !== 16'd0 || seen0[4].tap !== 8'd4) begin
      bad++; $display("FAIL pad_centre: got pad %b addr %0d tap %0d, want 0 0 4", seen0[4].pad, seen0[4].addr, seen0[4].tap);
    end
    total++;
    if (seen0[143].pad !== 1'b1 || seen0[143].win !== 8'd15 || done_at[0] != 145) begin
      bad++; $display("FAIL pad_last: got pad %b win %0d done@%0d, want 1 15 145", seen0[143].pad, seen0[143].win, done_at[0]);
    end
`else
    for (int i = 0; i < 9; i++) begin
      total++;
      if (seen0[i].addr !== 16'(exp_addr[i])) begin
        bad++; $display("FAIL addr_seq[%0d]: got %0d want %0d", i, seen0[i].addr, exp_addr[i]);
      end
    end
    total++;
    if (!seen0[0].clr || !seen0[9].clr || !seen0[8].last || !seen0[35].last || seen0[35].win !== 8'd3 || done_at[0] != 37) begin
      bad++; $display("FAIL window_marks: got clr %b%b last %b%b win %0d done@%0d, want 11 11 3 37",
                      seen0[0].clr, seen0[9].clr, seen0[8].last, seen0[35].last, seen0[35].win, done_at[0]);
    end
    total++;
    if (seen1[9].addr !== 16'd2 || seen1[18].addr !== 16'd12 || done_at[1] != 37) begin
      bad++; $display("FAIL stride2: got w1 %0d w2 %0d done@%0d, want 2 12 37", seen1[9].addr, seen1[18].addr, done_at[1]);
    end
`endif
  endtask

  task automatic test_stall();
    run_pass(1, 0, 0);
  endtask

  task automatic test_abort_restart();
    run_pass(0, 5, 20);
    run_pass(0, 0, 0);
    total++;
    if (seen0[0].addr !== 16'd0 || seen0[0].tap !== 8'd0 || seen0[0].win !== 8'd0) begin
      bad++; $display("FAIL fresh_start: got addr %0d tap %0d win %0d, want 0 0 0", seen0[0].addr, seen0[0].tap, seen0[0].win);
    end
  endtask

  task automatic test_async_reset();
    @(negedge CLK); start = 1'b1; adv = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (10) @(negedge CLK);
    total++;
    if (bus0.tap_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset_run: got tap_valid %b, want 1", bus0.tap_valid);
    end
    @(posedge CLK); #2; RESET = 1'b1; #1;
    check_idle("async_reset");
    @(negedge CLK); RESET = 1'b0; adv = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check_idle("reset_release");
    end
    run_pass(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_stall();
    test_abort_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
